round_sequencer: RTL and testbench
==================================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameters SHALL be: INTRO_FRAMES, default 120, dog intro length in frames; FLY_FRAMES, default 300, duck flight window before fly-away; FALL_FRAMES, default 60, falling-duck animation; AWAY_FRAMES, default 60, fly-away animation; DUCKS_PER_ROUND, default 10; SHOTS_PER_DUCK, default 3; PASS_HITS, default 6, minimum hits per round to continue.
REQ-002 Clk  in  1  system clock (MAX10_CLK1_50 domain); one clock; reset is asynchronous and active-low.
REQ-003 Reset_n  in  1  asynchronous active-low reset.
REQ-004 frame_tick  in  1  one-Clk pulse per video frame.
REQ-005 start  in  1  level from the Run key; a rising edge starts or restarts the game.
REQ-006 shoot_btn  in  1  left mouse button level (MouseButtons[0]).
REQ-007 on_duck  in  1  cursor overlaps the live duck; sampled only on a shot event.
REQ-008 shoot_enable  out  1  high only in FLY.
REQ-009 fly_away  out  1  high only in AWAY.
REQ-010 duck_kill  out  1  one-Clk pulse on a registered hit.
REQ-011 duck_reset  out  1  one-Clk pulse on every entry to FLY; spawns a new duck.
REQ-012 shots_left  out  2  remaining shots for the current duck.
REQ-013 duck_index  out  4  current duck, 0..DUCKS_PER_ROUND-1.
REQ-014 hits  out  10  per-duck hit bitmap for the current round.
REQ-015 round_number  out  8  current round, 1-based.
REQ-016 game_over  out  1  high only in OVER.

Function
REQ-017 States SHALL be IDLE, INTRO, FLY, FALL, AWAY, CHECK and OVER.
REQ-018 Shot event = shoot_btn high while previous-cycle shoot_btn low (one registered flop); events outside FLY or with shots_left=0 SHALL be ignored and SHALL NOT decrement shots_left.
REQ-019 The frame timer SHALL clear on every state entry and SHALL increment on frame_tick; a state's exit condition "timer = N" SHALL take effect on the Clk after the Nth tick.
REQ-020 IDLE->INTRO on start rising edge; round_number:=1, duck_index:=0, hits:=0.
REQ-021 INTRO->FLY at timer=INTRO_FRAMES; shots_left:=SHOTS_PER_DUCK, duck_reset pulses in the entry cycle.
REQ-022 FLY: a shot event with on_duck=1 SHALL go to FALL, set hits[duck_index], pulse duck_kill in the same cycle, and decrement shots_left.
REQ-023 FLY: a shot event with on_duck=0 SHALL decrement shots_left; when it reaches 0, next state AWAY.
REQ-024 FLY->AWAY at timer=FLY_FRAMES; a hit shot in the same cycle SHALL win (FALL).
REQ-025 FALL->next at FALL_FRAMES and AWAY->next at AWAY_FRAMES; next = CHECK if duck_index=DUCKS_PER_ROUND-1, else FLY with duck_index+1 and shots_left reloaded.
REQ-026 CHECK (one Clk): popcount(hits) >= PASS_HITS -> INTRO with round_number+1 (saturating at 99), duck_index:=0, hits:=0; otherwise -> OVER.
REQ-027 OVER: a start rising edge SHALL behave exactly as REQ-020.
REQ-028 A start edge in any state other than IDLE/OVER SHALL be ignored.
REQ-029 All outputs SHALL be registered or pure state decodes; no combinational path from inputs to outputs.

Reset
REQ-030 Reset_n low SHALL asynchronously force IDLE, timer=0, shots_left=0, duck_index=0, hits=0, round_number=0, all pulse/flag outputs 0, and the edge-detect flops to 0.
REQ-031 Reset assertion mid-round SHALL abandon the round; the first start edge after release SHALL begin round 1.

Structure
REQ-032 The state enum and default frame counts SHALL live in the shared package duck_pkg.
REQ-033 The frame timer SHALL be the sub-module frame_timer (clear, tick, 9-bit count).

Verification
REQ-034 Reset, start edge, 120 ticks -> FLY, shots_left=3, duck_reset pulses once, round_number=1.
REQ-035 In FLY, shot with on_duck=0 then with on_duck=1 -> shots_left 3->2->1, duck_kill pulses once, hits[0]=1, FALL.
REQ-036 Three misses -> shots_left=0, AWAY, fly_away=1; a fourth click produces no change.
REQ-037 Hit on the same Clk as the 300th tick -> FALL, not AWAY.
REQ-038 Ten ducks, 6 hits -> CHECK -> INTRO, round_number=2, hits=0; 5 hits -> OVER, game_over=1; then start -> round_number=1.
REQ-039 Reset_n pulsed low in FLY of round 3 -> all outputs at reset values immediately, IDLE held until start.

Source files
------------

// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - shared state encoding, default frame counts and helpers for the duck round sequencer
package duck_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INTRO = 3'd1,
        ST_FLY   = 3'd2,
        ST_FALL  = 3'd3,
        ST_AWAY  = 3'd4,
        ST_CHECK = 3'd5,
        ST_OVER  = 3'd6
    } duck_state_t;

    localparam int DEF_INTRO_FRAMES    = 120;
    localparam int DEF_FLY_FRAMES      = 300;
    localparam int DEF_FALL_FRAMES     = 60;
    localparam int DEF_AWAY_FRAMES     = 60;
    localparam int DEF_DUCKS_PER_ROUND = 10;
    localparam int DEF_SHOTS_PER_DUCK  = 3;
    localparam int DEF_PASS_HITS       = 6;

    localparam int ROUND_MAX   = 99;
    localparam int TIMER_WIDTH = 9;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - per-state frame counter, cleared on state entry and advanced by frame_tick
module frame_timer
    import duck_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   tick,
    output logic [TIMER_WIDTH-1:0] count
);

    // Saturates so a long stay in IDLE/OVER never wraps into a false match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != {TIMER_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - duck hunt round/duck/shot sequencer with frame-timed states
module round_sequencer
    import duck_pkg::*;
#(
    parameter int INTRO_FRAMES    = DEF_INTRO_FRAMES,
    parameter int FLY_FRAMES      = DEF_FLY_FRAMES,
    parameter int FALL_FRAMES     = DEF_FALL_FRAMES,
    parameter int AWAY_FRAMES     = DEF_AWAY_FRAMES,
    parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
    parameter int SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
    parameter int PASS_HITS       = DEF_PASS_HITS
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       shoot_btn,
    input  logic       on_duck,
    output logic       shoot_enable,
    output logic       fly_away,
    output logic       duck_kill,
    output logic       duck_reset,
    output logic [1:0] shots_left,
    output logic [3:0] duck_index,
    output logic [9:0] hits,
    output logic [7:0] round_number,
    output logic       game_over
);

    duck_state_t            state;
    duck_state_t            next_state;
    logic [TIMER_WIDTH-1:0] timer_count;
    logic                   timer_clear;
    logic                   start_q;
    logic                   shoot_q;
    logic                   start_rise;
    logic                   shot_ok;
    logic                   last_duck;
    logic                   load_game;
    logic                   next_round;
    logic                   reload_shots;
    logic                   advance_duck;
    logic                   do_kill;
    logic                   do_miss;

    assign start_rise = start && !start_q;
    assign shot_ok    = shoot_btn && !shoot_q && (state == ST_FLY) && (shots_left != 2'd0);
    assign last_duck  = (duck_index == 4'(DUCKS_PER_ROUND - 1));

    frame_timer u_frame_timer (
        .clk   (Clk),
        .rst_n (Reset_n),
        .clear (timer_clear),
        .tick  (frame_tick),
        .count (timer_count)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        load_game    = 1'b0;
        next_round   = 1'b0;
        reload_shots = 1'b0;
        advance_duck = 1'b0;
        do_kill      = 1'b0;
        do_miss      = 1'b0;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    next_state = ST_INTRO;
                    load_game  = 1'b1;
                end
            end
            ST_INTRO: begin
                if (timer_count == TIMER_WIDTH'(INTRO_FRAMES)) begin
                    next_state   = ST_FLY;
                    reload_shots = 1'b1;
                end
            end
            ST_FLY: begin
                // A hit outranks both the flight timeout and running out of shots.
                if (shot_ok && on_duck) begin
                    next_state = ST_FALL;
                    do_kill    = 1'b1;
                end else begin
                    do_miss = shot_ok;
                    if ((timer_count == TIMER_WIDTH'(FLY_FRAMES)) ||
                        (shot_ok && (shots_left == 2'd1))) begin
                        next_state = ST_AWAY;
                    end
                end
            end
            ST_FALL, ST_AWAY: begin
                if (((state == ST_FALL) && (timer_count == TIMER_WIDTH'(FALL_FRAMES))) ||
                    ((state == ST_AWAY) && (timer_count == TIMER_WIDTH'(AWAY_FRAMES)))) begin
                    if (last_duck) begin
                        next_state = ST_CHECK;
                    end else begin
                        next_state   = ST_FLY;
                        advance_duck = 1'b1;
                        reload_shots = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (32'(popcount10(hits)) >= PASS_HITS) begin
                    next_state = ST_INTRO;
                    next_round = 1'b1;
                end else begin
                    next_state = ST_OVER;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign timer_clear = (next_state != state);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_q      <= 1'b0;
            shoot_q      <= 1'b0;
            shots_left   <= 2'd0;
            duck_index   <= 4'd0;
            hits         <= 10'd0;
            round_number <= 8'd0;
            duck_kill    <= 1'b0;
            duck_reset   <= 1'b0;
        end else begin
            start_q    <= start;
            shoot_q    <= shoot_btn;
            duck_kill  <= do_kill;
            duck_reset <= (next_state == ST_FLY) && (state != ST_FLY);
            if (load_game) begin
                round_number <= 8'd1;
                duck_index   <= 4'd0;
                hits         <= 10'd0;
            end
            if (next_round) begin
                if (round_number < 8'(ROUND_MAX)) begin
                    round_number <= round_number + 8'd1;
                end
                duck_index <= 4'd0;
                hits       <= 10'd0;
            end
            if (advance_duck) begin
                duck_index <= duck_index + 4'd1;
            end
            if (reload_shots) begin
                shots_left <= 2'(SHOTS_PER_DUCK);
            end
            if (do_kill) begin
                hits <= hits | (10'd1 << duck_index);
            end
            if (do_kill || do_miss) begin
                shots_left <= shots_left - 2'd1;
            end
        end
    end

    assign shoot_enable = (state == ST_FLY);
    assign fly_away     = (state == ST_AWAY);
    assign game_over    = (state == ST_OVER);

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - scoreboard bench for round_sequencer
module tb_round_sequencer;

    localparam int EV_RESET = 0;
    localparam int EV_KILL  = 1;
    localparam int EV_AWAY  = 2;
    localparam int EV_OVER  = 3;

    typedef struct {
        int         kind;
        int         shots;
        int         idx;
        logic [9:0] h;
        int         rnd;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       shoot_btn = 1'b0;
    logic       on_duck = 1'b0;
    logic       shoot_enable;
    logic       fly_away;
    logic       duck_kill;
    logic       duck_reset;
    logic [1:0] shots_left;
    logic [3:0] duck_index;
    logic [9:0] hits;
    logic [7:0] round_number;
    logic       game_over;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       fly_away_d = 1'b0;
    logic       game_over_d = 1'b0;
    logic [9:0] m_hits;
    int         m_shots;

    round_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .start        (start),
        .shoot_btn    (shoot_btn),
        .on_duck      (on_duck),
        .shoot_enable (shoot_enable),
        .fly_away     (fly_away),
        .duck_kill    (duck_kill),
        .duck_reset   (duck_reset),
        .shots_left   (shots_left),
        .duck_index   (duck_index),
        .hits         (hits),
        .round_number (round_number),
        .game_over    (game_over)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {3'd0, shoot_enable, fly_away, duck_kill, duck_reset, game_over,
                shots_left, duck_index, hits, round_number};
    endfunction

    task automatic expect_ev(input int kind, input int shots, input int idx,
                             input logic [9:0] h, input int rnd);
        exp_t e;
        e.kind = kind; e.shots = shots; e.idx = idx; e.h = h; e.rnd = rnd;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d with nothing expected (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.shots != int'(shots_left) || e.idx != int'(duck_index) ||
                e.h !== hits || e.rnd != int'(round_number)) begin
                n_bad++;
                $display("FAIL event: got kind=%0d shots=%0d idx=%0d hits=%b round=%0d required kind=%0d shots=%0d idx=%0d hits=%b round=%0d (t=%0t)",
                         kind, shots_left, duck_index, hits, round_number,
                         e.kind, e.shots, e.idx, e.h, e.rnd, $time);
            end
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (duck_reset) got_ev(EV_RESET);
            if (duck_kill) got_ev(EV_KILL);
            if (fly_away && !fly_away_d) got_ev(EV_AWAY);
            if (game_over && !game_over_d) got_ev(EV_OVER);
        end
        fly_away_d  = fly_away;
        game_over_d = game_over;
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic shoot(input logic od);
        shoot_btn = 1'b1;
        on_duck   = od;
        @(negedge Clk);
        shoot_btn = 1'b0;
        on_duck   = 1'b0;
        @(negedge Clk);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic intro_to_fly(input int rnd);
        m_hits = 10'd0;
        expect_ev(EV_RESET, 3, 0, 10'd0, rnd);
        ticks(119);
        check("intro_before_120", {31'd0, shoot_enable}, 32'd0);
        ticks(1);
        check("fly_entry", {shoot_enable, shots_left, round_number}, {1'b1, 2'd3, 8'(rnd)});
    endtask

    task automatic play_duck(input int idx, input logic hit, input int rnd);
        if (hit) begin
            m_hits[idx] = 1'b1;
            m_shots = 2;
            expect_ev(EV_KILL, 2, idx, m_hits, rnd);
            shoot(1'b1);
        end else begin
            m_shots = 0;
            expect_ev(EV_AWAY, 0, idx, m_hits, rnd);
            repeat (3) shoot(1'b0);
        end
        if (idx < 9) begin
            expect_ev(EV_RESET, 3, idx + 1, m_hits, rnd);
            ticks(60);
        end else if ($countones(m_hits) >= 6) begin
            ticks(60);
            @(negedge Clk);
            check("check_pass", {hits, duck_index, round_number, game_over},
                  {10'd0, 4'd0, 8'(rnd + 1), 1'b0});
        end else begin
            expect_ev(EV_OVER, m_shots, 9, m_hits, rnd);
            ticks(60);
            @(negedge Clk);
            check("check_fail_over", {31'd0, game_over}, 32'd1);
        end
    endtask

    task automatic play_round(input int rnd, input logic [9:0] pat, input int first);
        for (int i = first; i < 10; i++) begin
            play_duck(i, pat[i], rnd);
        end
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("reset_outputs", all_outs(), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        start_pulse();
        check("start_round1", {round_number, duck_index, hits}, {8'd1, 4'd0, 10'd0});
        intro_to_fly(1);

        // Duck 0: miss then hit
        shoot(1'b0);
        check("miss_decrements", {30'd0, shots_left}, 32'd2);
        m_hits[0] = 1'b1;
        expect_ev(EV_KILL, 1, 0, m_hits, 1);
        shoot(1'b1);
        check("hit_goes_fall", {30'd0, shoot_enable, fly_away}, 32'd0);
        expect_ev(EV_RESET, 3, 1, m_hits, 1);
        ticks(60);

        // Duck 1: start ignored, three misses, fourth click inert
        start_pulse();
        check("start_ignored_in_fly", {shoot_enable, duck_index, round_number}, {1'b1, 4'd1, 8'd1});
        expect_ev(EV_AWAY, 0, 1, m_hits, 1);
        repeat (3) shoot(1'b0);
        check("three_misses_away", {fly_away, shots_left}, {1'b1, 2'd0});
        shoot(1'b0);
        check("fourth_click_inert", {fly_away, shoots_left_pad(), hits}, {1'b1, 2'd0, m_hits});
        expect_ev(EV_RESET, 3, 2, m_hits, 1);
        ticks(60);

        // Duck 2: hit lands in the cycle the flight timer reaches 300
        ticks(299);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        m_hits[2] = 1'b1;
        expect_ev(EV_KILL, 2, 2, m_hits, 1);
        shoot(1'b1);
        check("hit_beats_timeout", {30'd0, shoot_enable, fly_away}, 32'd0);
        expect_ev(EV_RESET, 3, 3, m_hits, 1);
        ticks(60);

        play_round(1, 10'b0001111101, 3);
        intro_to_fly(2);
        play_round(2, 10'b0000011111, 0);
        start_pulse();
        check("restart_from_over", {round_number, hits, game_over}, {8'd1, 10'd0, 1'b0});
        intro_to_fly(1);
        play_round(1, 10'b1111111111, 0);
        intro_to_fly(2);
        play_round(2, 10'b1010110101, 0);
        intro_to_fly(3);

        #2 Reset_n = 1'b0;
        #1 check("async_reset_in_fly", all_outs(), 32'd0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        ticks(130);
        shoot(1'b1);
        check("idle_held", all_outs(), 32'd0);
        start_pulse();
        check("restart_after_reset", {round_number, duck_index, hits}, {8'd1, 4'd0, 10'd0});
        repeat (2) @(negedge Clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic [1:0] shoots_left_pad();
        return shots_left;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
